pulse_cfg_loader: RTL and testbench
===================================

// Module: pulse_cfg_loader
// PURPOSE
// Configuration controller for the pulse_logic edge engine. Parses a byte-stream command protocol (fed by
// the host link/UART), builds a shadow copy of period, outer_period, state0 and the edge table, and
// atomically commits it to the active outputs that drive pulse_logic. Also owns pulse_logic's reset (run/stop).
// PARAMETERS
// COUNT_BITS  32   width of x/dx fields and of period/outer_period
// CH_LOG2     3    channel-ID width; CH_MAX = 1<<CH_LOG2 output channels
// ED_MAX      255  number of edge slots (must be 1..255, index carried in one byte)
// (localparams: ED_BITS = 2*COUNT_BITS+CH_LOG2+1; ED_BYTES = ceil(ED_BITS/8); PER_BYTES = ceil(COUNT_BITS/8))
// PORTS
// clk           in   1                 system clock; single clock domain
// reset         in   1                 synchronous, active-high
// rx_data       in   8                 command/payload byte
// rx_valid      in   1                 rx_data valid
// rx_ready      out  1                 byte accepted on rx_valid && rx_ready
// period        out  COUNT_BITS        active inner period to pulse_logic
// outer_period  out  COUNT_BITS        active outer period
// state0        out  CH_MAX            active initial channel state
// eds           out  ED_BITS*ED_MAX    active packed edge table (slot i at [i*ED_BITS +: ED_BITS])
// pl_reset      out  1                 reset to pulse_logic (high = stopped/restart)
// running       out  1                 1 after RUN, 0 after STOP/reset
// err           out  1                 sticky protocol error; cleared by reset or CLRERR
// BEHAVIOUR
// - Reset: all shadow and active regs -> period=1, outer_period=1, state0=0, eds=0; pl_reset=1, running=0,
//   err=0, rx_ready=1, FSM=IDLE. Reset mid-command discards the partial command; shadow never half-written.
// - Opcodes (first byte in IDLE): 0x01 SET_PER (PER_BYTES LE), 0x02 SET_OUTER (PER_BYTES LE),
//   0x03 SET_ST0 (1 byte, low CH_MAX bits used), 0x04 WR_EDGE (1 idx byte + ED_BYTES LE, low ED_BITS used),
//   0x05 CLR_EDGES (0 payload), 0x06 COMMIT, 0x07 RUN, 0x08 STOP, 0x09 CLRERR. Others: err<=1, stay IDLE.
// - FSM: IDLE -(opcode w/ payload)-> PAYLOAD -(last byte)-> WRITE -> IDLE; IDLE -(0-payload op)-> WRITE -> IDLE.
//   WRITE lasts exactly 1 cycle, rx_ready=0 during it; rx_ready=1 in IDLE and PAYLOAD.
// - Payload assembled LSB-first in a shift register; shadow reg updated in WRITE cycle, i.e. visible
//   the cycle after WRITE. Bytes beyond field width are ignored.
// - WR_EDGE idx >= ED_MAX: payload still fully consumed, no write, err<=1.
// - CLR_EDGES: all shadow edge slots zeroed in the WRITE cycle (enable bits 0 -> no edges).
// - COMMIT: in WRITE cycle, active <= shadow (all fields, one cycle, atomic); pl_reset=1 for exactly
//   that cycle so pulse_logic counters restart at 0 with new table. If stopped, pl_reset stays 1.
// - RUN: pl_reset<=0, running<=1 from cycle after WRITE. STOP: pl_reset<=1, running<=0. RUN when running: no-op.
// - SET_PER/SET_OUTER value 0 or negative (MSB set): rejected, shadow unchanged, err<=1.
// - Active outputs change only on COMMIT or reset; shadow edits never disturb a running waveform.
// - rx_valid low in PAYLOAD: FSM waits indefinitely (no timeout); byte count held.
// STRUCTURE
// - pulse_defs.vh (shared include): opcode constants, ED_BITS/ED_BYTES macros, reset defaults; also used by
//   pulse_logic instantiation in top level and by host-side test vectors.
// - Sub-module pulse_cfg_shift: byte-to-word LE shift assembler with byte counter and done flag
//   (params WORD_BYTES); one instance sized ED_BYTES+1, narrower fields take low bits.
// - Shadow/active edge tables as flat registers; slot write via idx-decoded enables.
// TESTING
// - Reset, then COMMIT,RUN -> period=1, outer_period=1, eds=0, pl_reset 1 for WRITE cycle then 0, running=1.
// - WR_EDGE idx=2, x=5,dx=0,ch=3,en=1; SET_PER 10; COMMIT -> eds slot2 = {1,3'd3,32'd0,32'd5}, period=10;
//   outputs unchanged before COMMIT's WRITE cycle, pl_reset pulse 1 cycle.
// - While running, WR_EDGE idx=7 then check eds unchanged until COMMIT; then active slot7 updated same cycle.
// - WR_EDGE idx=255 (ED_MAX=255) -> err=1, next opcode still parsed correctly; CLRERR -> err=0.
// - Opcode 0xAA -> err=1; SET_PER 0 -> err=1, shadow period unchanged after COMMIT.
// - Reset asserted after 4 of 10 WR_EDGE payload bytes -> FSM IDLE, no shadow change; backpressure:
//   rx_valid toggled randomly in PAYLOAD yields identical result; rx_ready=0 only in WRITE cycles.

Source files
------------

// File: rtl/pulse_cfg_loader_pkg.sv
// Shared definitions for the pulse_logic configuration loader: default
// geometry, command opcodes, parser FSM states and sizing helpers.
package pulse_cfg_loader_pkg;

  localparam int DEF_COUNT_BITS = 32;
  localparam int DEF_CH_LOG2    = 3;
  localparam int DEF_ED_MAX     = 255;

  localparam logic [7:0] OP_SET_PER   = 8'h01;
  localparam logic [7:0] OP_SET_OUTER = 8'h02;
  localparam logic [7:0] OP_SET_ST0   = 8'h03;
  localparam logic [7:0] OP_WR_EDGE   = 8'h04;
  localparam logic [7:0] OP_CLR_EDGES = 8'h05;
  localparam logic [7:0] OP_COMMIT    = 8'h06;
  localparam logic [7:0] OP_RUN       = 8'h07;
  localparam logic [7:0] OP_STOP      = 8'h08;
  localparam logic [7:0] OP_CLRERR    = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_WRITE   = 2'd2
  } cfg_state_t;

  // Edge record: {en, ch, dx, x}
  function automatic int ed_bits(input int count_bits, input int ch_log2);
    return 2 * count_bits + ch_log2 + 1;
  endfunction

  function automatic int bytes_for(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/pulse_cfg_loader_shift.sv
// Little-endian byte-lane assembler: byte n of a payload lands in
// word[n*8 +: 8]. Cleared on start so fields shorter than the word read
// zeros above their last byte. done marks the byte that completes len.
module pulse_cfg_shift
  import pulse_cfg_loader_pkg::*;
#(
  parameter int WORD_BYTES = 10,
  parameter int CNT_W      = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic [CNT_W-1:0]        len,
  output logic [WORD_BYTES*8-1:0] word,
  output logic                    done
);

  logic [CNT_W-1:0] count;

  assign done = in_valid && (count == len - CNT_W'(1));

  // Place each accepted byte in the lane selected by the byte counter
  always_ff @(posedge clk) begin
    if (reset || start) begin
      word  <= '0;
      count <= '0;
    end else if (in_valid) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (count == CNT_W'(b)) word[b*8 +: 8] <= in_data;
      end
      if (count != CNT_W'(WORD_BYTES)) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_cfg_loader.sv
// Byte-stream configuration controller for pulse_logic. Commands edit a
// shadow copy of the waveform set; COMMIT copies it to the active outputs
// in one cycle while holding pulse_logic in reset for that cycle.
// rx handshake: a byte transfers on a rising clk edge where rx_valid and
// rx_ready are both high; rx_ready is low only during the one-cycle WRITE.
module pulse_cfg_loader
  import pulse_cfg_loader_pkg::*;
#(
  parameter int COUNT_BITS = DEF_COUNT_BITS,
  parameter int CH_LOG2    = DEF_CH_LOG2,
  parameter int ED_MAX     = DEF_ED_MAX
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [7:0]                                rx_data,
  input  logic                                      rx_valid,
  output logic                                      rx_ready,
  output logic [COUNT_BITS-1:0]                     period,
  output logic [COUNT_BITS-1:0]                     outer_period,
  output logic [(1<<CH_LOG2)-1:0]                   state0,
  output logic [(2*COUNT_BITS+CH_LOG2+1)*ED_MAX-1:0] eds,
  output logic                                      pl_reset,
  output logic                                      running,
  output logic                                      err,
  output logic [1:0]                                dbg_state
);

  localparam int CH_MAX     = 1 << CH_LOG2;
  localparam int ED_BITS    = ed_bits(COUNT_BITS, CH_LOG2);
  localparam int ED_BYTES   = bytes_for(ED_BITS);
  localparam int PER_BYTES  = bytes_for(COUNT_BITS);
  localparam int WORD_BYTES = ED_BYTES + 1;
  localparam int CNT_W      = $clog2(WORD_BYTES + 1);

  cfg_state_t state, state_next;
  logic [7:0] op;
  logic op_load, bad_op, shift_start, shift_valid, shift_done;
  logic [CNT_W-1:0] shift_len;
  logic [WORD_BYTES*8-1:0] word;

  logic [COUNT_BITS-1:0]     shadow_period, shadow_outer;
  logic [CH_MAX-1:0]         shadow_st0;
  logic [ED_BITS*ED_MAX-1:0] shadow_eds;

  logic [COUNT_BITS-1:0] per_val;
  logic                  per_ok;
  logic [7:0]            edge_idx;
  logic [ED_BITS-1:0]    edge_val;

  // Payload field views; WR_EDGE carries its slot index in the first byte
  assign per_val  = word[COUNT_BITS-1:0];
  assign per_ok   = (per_val != '0) && !per_val[COUNT_BITS-1];
  assign edge_idx = word[7:0];
  assign edge_val = word[8 +: ED_BITS];

  if (WORD_BYTES * 8 > ED_BITS + 8) begin : g_pad
    logic unused_word_hi;
    assign unused_word_hi = ^word[WORD_BYTES*8-1:ED_BITS+8];
  end

  assign rx_ready    = (state != ST_WRITE);
  assign shift_valid = rx_valid && (state == ST_PAYLOAD);
  assign pl_reset    = !running || (state == ST_WRITE && op == OP_COMMIT);
  assign dbg_state   = state;

  pulse_cfg_shift #(.WORD_BYTES(WORD_BYTES), .CNT_W(CNT_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .start    (shift_start),
    .in_valid (shift_valid),
    .in_data  (rx_data),
    .len      (shift_len),
    .word     (word),
    .done     (shift_done)
  );

  // Payload length of the command being assembled
  always_comb begin
    shift_len = CNT_W'(WORD_BYTES);
    case (op)
      OP_SET_PER, OP_SET_OUTER: shift_len = CNT_W'(PER_BYTES);
      OP_SET_ST0:               shift_len = CNT_W'(1);
      default:                  shift_len = CNT_W'(WORD_BYTES);
    endcase
  end

  // Parser state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Parser next state: opcode decode, payload collection, single WRITE cycle
  always_comb begin
    state_next  = state;
    op_load     = 1'b0;
    bad_op      = 1'b0;
    shift_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_SET_PER, OP_SET_OUTER, OP_SET_ST0, OP_WR_EDGE: begin
              op_load     = 1'b1;
              shift_start = 1'b1;
              state_next  = ST_PAYLOAD;
            end
            OP_CLR_EDGES, OP_COMMIT, OP_RUN, OP_STOP, OP_CLRERR: begin
              op_load    = 1'b1;
              state_next = ST_WRITE;
            end
            default: bad_op = 1'b1;
          endcase
        end
      end
      ST_PAYLOAD: if (shift_done) state_next = ST_WRITE;
      ST_WRITE:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Shadow edits, atomic commit, run/stop and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      op            <= '0;
      shadow_period <= COUNT_BITS'(1);
      shadow_outer  <= COUNT_BITS'(1);
      shadow_st0    <= '0;
      shadow_eds    <= '0;
      period        <= COUNT_BITS'(1);
      outer_period  <= COUNT_BITS'(1);
      state0        <= '0;
      eds           <= '0;
      running       <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (op_load) op <= rx_data;
      if (bad_op) err <= 1'b1;
      if (state == ST_WRITE) begin
        case (op)
          OP_SET_PER: begin
            if (per_ok) shadow_period <= per_val;
            else        err <= 1'b1;
          end
          OP_SET_OUTER: begin
            if (per_ok) shadow_outer <= per_val;
            else        err <= 1'b1;
          end
          OP_SET_ST0: shadow_st0 <= word[CH_MAX-1:0];
          OP_WR_EDGE: begin
            if (int'(edge_idx) >= ED_MAX) begin
              err <= 1'b1;
            end else begin
              for (int i = 0; i < ED_MAX; i++) begin
                if (int'(edge_idx) == i) shadow_eds[i*ED_BITS +: ED_BITS] <= edge_val;
              end
            end
          end
          OP_CLR_EDGES: shadow_eds <= '0;
          OP_COMMIT: begin
            period       <= shadow_period;
            outer_period <= shadow_outer;
            state0       <= shadow_st0;
            eds          <= shadow_eds;
          end
          OP_RUN:    running <= 1'b1;
          OP_STOP:   running <= 1'b0;
          OP_CLRERR: err <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_cfg_loader.sv
// Bench for pulse_cfg_loader: fixed command table, timed corner-case
// sequences and randomized commands checked against a command-level model.
module tb_pulse_cfg_loader;

  localparam int CB = 32;
  localparam int EB = 68;
  localparam int EM = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [CB-1:0]    period, outer_period;
  logic [7:0]       state0;
  logic [EB*EM-1:0] eds;
  logic             pl_reset, running, err;
  logic [1:0]       dbg_state;

  pulse_cfg_loader dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .period       (period),
    .outer_period (outer_period),
    .state0       (state0),
    .eds          (eds),
    .pl_reset     (pl_reset),
    .running      (running),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int last_waits = 0;
  int ready_low = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (mon_en && rx_ready === 1'b0) ready_low++;

  // ---------------- reference model (command level) ----------------
  logic [CB-1:0] m_sh_per, m_sh_out, m_act_per, m_act_out;
  logic [7:0]    m_sh_st0, m_act_st0;
  logic [EB-1:0] m_sh_edge [EM];
  logic [EB-1:0] m_act_edge[EM];
  bit            m_run, m_err;
  int            m_writes = 0;

  logic [7:0]  tx_q[$];
  logic [74:0] exp_q[$];

  task automatic model_reset();
    m_sh_per = 1; m_sh_out = 1; m_act_per = 1; m_act_out = 1;
    m_sh_st0 = 0; m_act_st0 = 0; m_run = 0; m_err = 0;
    for (int i = 0; i < EM; i++) begin
      m_sh_edge[i] = '0;
      m_act_edge[i] = '0;
    end
  endtask

  // Interpret the complete command currently held in tx_q
  task automatic model_cmd();
    logic [7:0]  op;
    logic [31:0] v;
    logic [71:0] w;
    int idx;
    op = tx_q[0];
    case (op)
      8'h01, 8'h02: begin
        m_writes++;
        v = {tx_q[4], tx_q[3], tx_q[2], tx_q[1]};
        if ($signed(v) <= 0) m_err = 1;
        else if (op == 8'h01) m_sh_per = v;
        else m_sh_out = v;
      end
      8'h03: begin m_writes++; m_sh_st0 = tx_q[1]; end
      8'h04: begin
        m_writes++;
        idx = int'(tx_q[1]);
        w = '0;
        for (int k = 0; k < 9; k++) w = w | (72'(tx_q[2+k]) << (8 * k));
        if (idx >= EM) m_err = 1;
        else m_sh_edge[idx] = w[EB-1:0];
      end
      8'h05: begin m_writes++; for (int i = 0; i < EM; i++) m_sh_edge[i] = '0; end
      8'h06: begin
        m_writes++;
        m_act_per = m_sh_per; m_act_out = m_sh_out; m_act_st0 = m_sh_st0;
        for (int i = 0; i < EM; i++) m_act_edge[i] = m_sh_edge[i];
      end
      8'h07: begin m_writes++; m_run = 1; end
      8'h08: begin m_writes++; m_run = 0; end
      8'h09: begin m_writes++; m_err = 0; end
      default: m_err = 1;
    endcase
    exp_q.push_back({m_act_per, m_act_out, m_act_st0, m_run, !m_run, m_err});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_all(input string name);
    logic [74:0] e;
    int bad;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_queue actual=empty expected=entry", name);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_outs"}, {period, outer_period, state0, running, pl_reset, err}, e);
    bad = -1;
    for (int i = 0; i < EM; i++)
      if (bad < 0 && eds[i*EB +: EB] !== m_act_edge[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_eds slot=%0d actual=%0h expected=%0h", name, bad,
               eds[bad*EB +: EB], m_act_edge[bad]);
    end
  endtask

  // ---------------- drivers ----------------
  // Called and returns on a negedge; returns the negedge after acceptance
  task automatic send_byte(input logic [7:0] b, input bit bp);
    int gap;
    if (bp) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        rx_valid = 1'b0; rx_data = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1; rx_data = b; last_waits = 0;
    while (rx_ready !== 1'b1 && last_waits < 20) begin
      @(negedge clk);
      last_waits++;
    end
    if (rx_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=%0b expected=1", rx_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic send_cmd(input string name, input bit bp);
    model_cmd();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), bp);
    @(negedge clk);
    check_all(name);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; rx_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic push_edge(input logic [7:0] idx, input logic [71:0] v);
    tx_q.push_back(8'h04); tx_q.push_back(idx);
    for (int k = 0; k < 9; k++) tx_q.push_back(v[k*8 +: 8]);
  endtask

  task automatic push_per(input logic [7:0] op, input logic [31:0] v);
    tx_q.push_back(op);
    for (int k = 0; k < 4; k++) tx_q.push_back(v[k*8 +: 8]);
  endtask

  // COMMIT with checks inside its WRITE cycle and on the cycle after
  task automatic timed_commit(input string name, input int slot, input logic [EB-1:0] old_v,
                              input logic [EB-1:0] new_v, input logic [31:0] old_p,
                              input logic [31:0] new_p);
    tx_q.push_back(8'h06);
    model_cmd();
    send_byte(tx_q.pop_front(), 1'b0);
    check({name, "_pl_write"}, pl_reset, 1'b1);
    check({name, "_ready_write"}, rx_ready, 1'b0);
    check({name, "_state_write"}, dbg_state, 2'd2);
    check({name, "_slot_before"}, eds[slot*EB +: EB], old_v);
    check({name, "_per_before"}, period, old_p);
    @(negedge clk);
    check({name, "_slot_after"}, eds[slot*EB +: EB], new_v);
    check({name, "_per_after"}, period, new_p);
    check({name, "_pl_after"}, pl_reset, 1'b0);
    check_all(name);
  endtask

  task automatic gen_random_cmd();
    int sel;
    logic [31:0] v;
    logic [71:0] ev;
    sel = $urandom_range(0, 11);
    case (sel)
      0, 1: begin
        case ($urandom_range(0, 5))
          0: v = 32'd0;
          1: v = 32'h8000_0000 | $urandom;
          default: v = $urandom_range(1, 1000);
        endcase
        push_per((sel == 0) ? 8'h01 : 8'h02, v);
      end
      2: begin tx_q.push_back(8'h03); tx_q.push_back(8'($urandom)); end
      3, 4: begin
        ev = {$urandom, $urandom, $urandom};
        push_edge($urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(248, 255)), ev);
      end
      5: tx_q.push_back(8'h05);
      6, 7: tx_q.push_back(8'h06);
      8: tx_q.push_back(8'h07);
      9: tx_q.push_back(8'h08);
      10: tx_q.push_back(8'h09);
      default: tx_q.push_back($urandom_range(0, 1) ? 8'($urandom_range(10, 255)) : 8'h00);
    endcase
  endtask

  // ---------------- command table ----------------
  typedef struct packed {
    logic [3:0]      n;
    logic [4:0][7:0] b;
    logic            exp_err;
    logic            exp_run;
    logic            exp_pl;
    logic [31:0]     exp_per;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] n, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                               input logic e, input logic r, input logic p, input logic [31:0] per);
    vec_t v;
    v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.exp_err = e; v.exp_run = r; v.exp_pl = p; v.exp_per = per;
    return v;
  endfunction

  vec_t vecs[14];

  localparam logic [EB-1:0] ED2 = {1'b1, 3'd3, 32'd0, 32'd5};
  localparam logic [EB-1:0] ED7 = {1'b1, 3'd5, 32'd3, 32'd100};

  initial begin
    vecs[0]  = mkv(1, 8'hAA, 0, 0, 0, 0,     1, 0, 1, 1);
    vecs[1]  = mkv(1, 8'h09, 0, 0, 0, 0,     0, 0, 1, 1);
    vecs[2]  = mkv(1, 8'h06, 0, 0, 0, 0,     0, 0, 1, 1);
    vecs[3]  = mkv(1, 8'h07, 0, 0, 0, 0,     0, 1, 0, 1);
    vecs[4]  = mkv(1, 8'h07, 0, 0, 0, 0,     0, 1, 0, 1);
    vecs[5]  = mkv(5, 8'h01, 0, 0, 0, 0,     1, 1, 0, 1);
    vecs[6]  = mkv(1, 8'h09, 0, 0, 0, 0,     0, 1, 0, 1);
    vecs[7]  = mkv(5, 8'h01, 0, 0, 0, 8'h80, 1, 1, 0, 1);
    vecs[8]  = mkv(1, 8'h09, 0, 0, 0, 0,     0, 1, 0, 1);
    vecs[9]  = mkv(5, 8'h01, 8'h0A, 0, 0, 0, 0, 1, 0, 1);
    vecs[10] = mkv(1, 8'h06, 0, 0, 0, 0,     0, 1, 0, 10);
    vecs[11] = mkv(1, 8'h08, 0, 0, 0, 0,     0, 0, 1, 10);
    vecs[12] = mkv(1, 8'h00, 0, 0, 0, 0,     1, 0, 1, 10);
    vecs[13] = mkv(1, 8'h09, 0, 0, 0, 0,     0, 0, 1, 10);

    rx_valid = 1'b0; rx_data = 8'h00; reset = 1'b1;
    @(negedge clk);
    do_reset(3);
    mon_en = 1'b1;

    // Reset values
    check("rst_period", period, 32'd1);
    check("rst_outer", outer_period, 32'd1);
    check("rst_state0", state0, 8'd0);
    check("rst_eds_zero", (eds == '0), 1'b1);
    check("rst_pl_reset", pl_reset, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", rx_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);

    // Table of single commands with hand-derived outcomes
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < int'(vecs[i].n); k++) tx_q.push_back(vecs[i].b[k]);
      send_cmd("tbl", 1'b0);
      check($sformatf("tbl%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("tbl%0d_run", i), running, vecs[i].exp_run);
      check($sformatf("tbl%0d_pl", i), pl_reset, vecs[i].exp_pl);
      check($sformatf("tbl%0d_per", i), period, vecs[i].exp_per);
    end

    // Edge slot 2 plus new period, committed while running
    tx_q.push_back(8'h07); send_cmd("run", 1'b0);
    push_edge(8'd2, {4'h0, ED2}); send_cmd("wr2", 1'b0);
    push_per(8'h01, 32'd12); send_cmd("per12", 1'b0);
    check("per_before_commit", period, 32'd10);
    timed_commit("commit2", 2, '0, ED2, 32'd10, 32'd12);

    // Shadow edit while running leaves active table alone until COMMIT
    push_edge(8'd7, {4'hF, ED7}); send_cmd("wr7", 1'b1);
    check("slot7_held", eds[7*EB +: EB], '0);
    check("slot2_held", eds[2*EB +: EB], ED2);
    timed_commit("commit7", 7, '0, ED7, 32'd12, 32'd12);

    // Byte offered during WRITE must wait one cycle
    tx_q.push_back(8'h09); model_cmd(); send_byte(tx_q.pop_front(), 1'b0);
    tx_q.push_back(8'h07); model_cmd(); send_byte(tx_q.pop_front(), 1'b0);
    check("write_stall_waits", last_waits, 1);
    @(negedge clk);
    check_all("b2b_a");
    check_all("b2b_b");

    // Out-of-range slot: error, payload consumed, next opcode parsed
    push_edge(8'd255, {$urandom, $urandom, $urandom}); send_cmd("wr255", 1'b0);
    check("wr255_err", err, 1'b1);
    tx_q.push_back(8'h03); tx_q.push_back(8'h5A); send_cmd("st0", 1'b0);
    tx_q.push_back(8'h06); send_cmd("commit_st0", 1'b0);
    check("st0_value", state0, 8'h5A);
    check("st0_err_sticky", err, 1'b1);
    tx_q.push_back(8'h09); send_cmd("clrerr", 1'b0);
    check("clrerr_err", err, 1'b0);

    // Clear all edges
    tx_q.push_back(8'h05); send_cmd("clr", 1'b0);
    tx_q.push_back(8'h06); send_cmd("commit_clr", 1'b0);
    check("clr_eds_zero", (eds == '0), 1'b1);
    check("clr_running", running, 1'b1);

    // Reset after 4 of 10 WR_EDGE payload bytes
    send_byte(8'h04, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    do_reset(2);
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_ready", rx_ready, 1'b1);
    check("midrst_running", running, 1'b0);
    tx_q.push_back(8'h06); send_cmd("midrst_commit", 1'b0);
    check("midrst_eds_zero", (eds == '0), 1'b1);
    check("midrst_period", period, 32'd1);

    // Randomized commands with random backpressure
    for (int n = 0; n < 200; n++) begin
      gen_random_cmd();
      send_cmd("rnd", 1'($urandom_range(0, 1)));
    end

    check("ready_low_cycles", ready_low, m_writes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
